// File: rtl/fft_output_sequencer.sv
// Output-side sequencer for the FFT: prepare/count FSM with backpressure, frame chaining and overrun flag.
// Optional OUTSEQ_BITREV_EN: index_o is the bit-reversed counter instead of the natural counter.
module fft_output_sequencer #(
  parameter int unsigned POINTS_LOG2 = 6,
  parameter int unsigned PREP_CYCLES = 1,
  parameter int unsigned CTRL_BEATS  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dataind,
  input  logic                   out_ready,
  output logic [POINTS_LOG2-1:0] counter_o,
  output logic [POINTS_LOG2-1:0] index_o,
  output logic                   datavalid,
  output logic                   in_ctrl_all_out,
  output logic                   hold_all_out,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned PW = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
  localparam int unsigned CW = POINTS_LOG2 + 1;
  localparam logic [PW-1:0]          PREP_LAST  = PW'(PREP_CYCLES - 1);
  localparam logic [POINTS_LOG2-1:0] CNT_LAST   = '1;
  localparam logic [CW-1:0]          CTRL_LIM   = CW'(CTRL_BEATS);
  localparam logic                   CTRL_FIRST = (CTRL_BEATS > 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREPARE  = 2'd1,
    COUNTING = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [POINTS_LOG2-1:0]   counter_q, counter_d;
  logic [PW-1:0]            prep_q, prep_d;
  logic                     pending_q, pending_d;
  logic                     datavalid_q, datavalid_d;
  logic                     in_ctrl_q, in_ctrl_d;
  logic                     hold_q, hold_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     accept;
  logic                     last_accept;
  logic [CW-1:0]            next_cnt;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      counter_q    <= '1;
      prep_q       <= '0;
      pending_q    <= 1'b0;
      datavalid_q  <= 1'b0;
      in_ctrl_q    <= 1'b0;
      hold_q       <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      prep_q       <= prep_d;
      pending_q    <= pending_d;
      datavalid_q  <= datavalid_d;
      in_ctrl_q    <= in_ctrl_d;
      hold_q       <= hold_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign accept      = datavalid_q & out_ready;
  assign last_accept = accept && (counter_q == CNT_LAST);
  assign next_cnt    = {1'b0, counter_q} + CW'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    prep_d       = prep_q;
    pending_d    = pending_q;
    datavalid_d  = datavalid_q;
    in_ctrl_d    = in_ctrl_q;
    hold_d       = hold_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dataind) begin
          state_d   = PREPARE;
          prep_d    = '0;
          in_ctrl_d = 1'b1;
          hold_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      PREPARE: begin
        in_ctrl_d = 1'b1;
        prep_d    = prep_q + PW'(1);
        if (prep_q == PREP_LAST) begin
          state_d     = COUNTING;
          counter_d   = '0;
          datavalid_d = 1'b1;
          in_ctrl_d   = CTRL_FIRST;
        end
      end
      COUNTING: begin
        if (last_accept) begin
          frame_done_d = 1'b1;
          counter_d    = '1;
          pending_d    = 1'b0;
          datavalid_d  = 1'b0;
          if (pending_q || dataind) begin
            state_d   = PREPARE;
            prep_d    = '0;
            in_ctrl_d = 1'b1;
          end else begin
            state_d   = IDLE;
            in_ctrl_d = 1'b0;
            hold_d    = 1'b1;
            busy_d    = 1'b0;
          end
        end else if (accept) begin
          counter_d = next_cnt[POINTS_LOG2-1:0];
          in_ctrl_d = (next_cnt < CTRL_LIM);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start request during a frame is queued once; a second one is dropped
    if (busy_q && dataind && !last_accept) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  assign counter_o       = counter_q;
  assign datavalid       = datavalid_q;
  assign in_ctrl_all_out = in_ctrl_q;
  assign hold_all_out    = hold_q;
  assign frame_done      = frame_done_q;
  assign busy            = busy_q;
  assign overrun         = overrun_q;

`ifdef OUTSEQ_BITREV_EN
  always_comb begin
    index_o = '0;
    for (int i = 0; i < int'(POINTS_LOG2); i++) begin
      index_o[i] = counter_q[int'(POINTS_LOG2) - 1 - i];
    end
  end
`else
  assign index_o = counter_q;
`endif

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Scoreboard bench for fft_output_sequencer: a default instance (64 points) and a small 16-point instance.
module tb_fft_output_sequencer;

  localparam int PA = 6;
  localparam int NA = 64;
  localparam int CA = 7;
  localparam int PB = 4;
  localparam int NB = 16;
  localparam int PRB = 3;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic dataind_a, ready_a, dataind_b, ready_b;
  logic [PA-1:0] counter_a, index_a;
  logic [PB-1:0] counter_b, index_b;
  logic datavalid_a, in_ctrl_a, hold_a, frame_done_a, busy_a, overrun_a;
  logic datavalid_b, in_ctrl_b, hold_b, frame_done_b, busy_b, overrun_b;

  int errors = 0;
  int checks = 0;
  int fd_a = 0, ov_a = 0, fd_b = 0, ov_b = 0;

  typedef struct {
    int cnt;
    int ctrl;
    int idx;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  always #5 clk = ~clk;

  fft_output_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .dataind(dataind_a), .out_ready(ready_a),
    .counter_o(counter_a), .index_o(index_a), .datavalid(datavalid_a),
    .in_ctrl_all_out(in_ctrl_a), .hold_all_out(hold_a), .frame_done(frame_done_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  fft_output_sequencer #(.POINTS_LOG2(PB), .PREP_CYCLES(PRB), .CTRL_BEATS(CB)) dut_b (
    .clk(clk), .rst_n(rst_n), .dataind(dataind_b), .out_ready(ready_b),
    .counter_o(counter_b), .index_o(index_b), .datavalid(datavalid_b),
    .in_ctrl_all_out(in_ctrl_b), .hold_all_out(hold_b), .frame_done(frame_done_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_idx(input int v, input int w);
    int r;
    r = v;
`ifdef OUTSEQ_BITREV_EN
    r = 0;
    for (int i = 0; i < w; i++) if (((v >> i) & 1) != 0) r |= (1 << (w - 1 - i));
`endif
    return r;
  endfunction

  task automatic push_a();
    for (int c = 0; c < NA; c++) qa.push_back('{c, (c < CA) ? 1 : 0, exp_idx(c, PA)});
  endtask

  task automatic push_b();
    for (int c = 0; c < NB; c++) qb.push_back('{c, (c < CB) ? 1 : 0, exp_idx(c, PB)});
  endtask

  // Beats are compared on the falling edge; the accept happens at the following rising edge
  always @(negedge clk) begin : mon_a
    beat_t e;
    if (rst_n) begin
      if (frame_done_a) fd_a++;
      if (overrun_a) ov_a++;
      if (datavalid_a && ready_a) begin
        if (qa.size() == 0) check("a_extra_beat", 32'(qa.size()), 32'd1);
        else begin
          e = qa.pop_front();
          check("a_counter", 32'(counter_a), 32'(e.cnt));
          check("a_in_ctrl", 32'(in_ctrl_a), 32'(e.ctrl));
          check("a_index", 32'(index_a), 32'(e.idx));
          check("a_hold_in_beat", 32'(hold_a), 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t e;
    if (rst_n) begin
      if (frame_done_b) fd_b++;
      if (overrun_b) ov_b++;
      if (datavalid_b && ready_b) begin
        if (qb.size() == 0) check("b_extra_beat", 32'(qb.size()), 32'd1);
        else begin
          e = qb.pop_front();
          check("b_counter", 32'(counter_b), 32'(e.cnt));
          check("b_in_ctrl", 32'(in_ctrl_b), 32'(e.ctrl));
          check("b_index", 32'(index_b), 32'(e.idx));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    dataind_a = 1'b1;
    step();
    dataind_a = 1'b0;
  endtask

  task automatic wait_cnt_a(input int v, input string tag);
    int found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (datavalid_a && int'(counter_a) == v) found = 1;
      else step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_frames_a(input int target, input string tag, output int hold_hi);
    int done = 0;
    hold_hi = 0;
    for (int i = 0; i < 2000 && done < target; i++) begin
      step();
      if (frame_done_a) done++;
      else if (hold_a) hold_hi++;
    end
    check(tag, 32'(done), 32'(target));
  endtask

  initial begin
    int hh, fd0, ov0, done;
    rst_n = 1'b1; dataind_a = 1'b0; dataind_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_counter", 32'(counter_a), 32'd63);
    check("rst_index", 32'(index_a), 32'(exp_idx(63, PA)));
    check("rst_datavalid", 32'(datavalid_a), 32'd0);
    check("rst_in_ctrl", 32'(in_ctrl_a), 32'd0);
    check("rst_hold", 32'(hold_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_frame_done", 32'(frame_done_a), 32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    check("rst_b_counter", 32'(counter_b), 32'd15);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single frame, no backpressure
    push_a();
    pulse_a();
    check("t1_c1_in_ctrl", 32'(in_ctrl_a), 32'd1);
    check("t1_c1_hold", 32'(hold_a), 32'd0);
    check("t1_c1_datavalid", 32'(datavalid_a), 32'd0);
    check("t1_c1_busy", 32'(busy_a), 32'd1);
    step();
    check("t1_c2_datavalid", 32'(datavalid_a), 32'd1);
    check("t1_c2_counter", 32'(counter_a), 32'd0);
    wait_frames_a(1, "t1_frames", hh);
    check("t1_hold_in_frame", 32'(hh), 32'd0);
    check("t1_end_hold", 32'(hold_a), 32'd1);
    check("t1_end_busy", 32'(busy_a), 32'd0);
    check("t1_end_datavalid", 32'(datavalid_a), 32'd0);
    step();
    check("t1_fd_count", 32'(fd_a), 32'd1);
    check("t1_q_empty", 32'(qa.size()), 32'd0);

    // Backpressure at counter 10
    fd0 = fd_a;
    push_a();
    pulse_a();
    wait_cnt_a(10, "t2_reach10");
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_counter", 32'(counter_a), 32'd10);
      check("t2_stall_valid", 32'(datavalid_a), 32'd1);
    end
    ready_a = 1'b1;
    step();
    check("t2_resume", 32'(counter_a), 32'd11);
    wait_frames_a(1, "t2_frames", hh);
    step();
    check("t2_fd_count", 32'(fd_a - fd0), 32'd1);
    check("t2_q_empty", 32'(qa.size()), 32'd0);

    // Back-to-back frames via pending
    fd0 = fd_a; ov0 = ov_a;
    push_a();
    pulse_a();
    wait_cnt_a(40, "t3_reach40");
    push_a();
    pulse_a();
    wait_frames_a(2, "t3_frames", hh);
    check("t3_hold_never_high", 32'(hh), 32'd0);
    step();
    check("t3_fd_count", 32'(fd_a - fd0), 32'd2);
    check("t3_no_overrun", 32'(ov_a - ov0), 32'd0);
    check("t3_q_empty", 32'(qa.size()), 32'd0);
    check("t3_idle_hold", 32'(hold_a), 32'd1);

    // Overrun: second request while pending is dropped
    fd0 = fd_a; ov0 = ov_a;
    push_a();
    pulse_a();
    wait_cnt_a(5, "t4_reach5");
    push_a();
    pulse_a();
    wait_cnt_a(20, "t4_reach20");
    pulse_a();
    wait_frames_a(2, "t4_frames", hh);
    repeat (4) step();
    check("t4_overrun_once", 32'(ov_a - ov0), 32'd1);
    check("t4_fd_count", 32'(fd_a - fd0), 32'd2);
    check("t4_q_empty", 32'(qa.size()), 32'd0);
    check("t4_idle_busy", 32'(busy_a), 32'd0);

    // Asynchronous reset mid-frame
    push_a();
    pulse_a();
    wait_cnt_a(30, "t5_reach30");
    fd0 = fd_a;
    #2 rst_n = 1'b0;
    #1;
    check("t5_hold", 32'(hold_a), 32'd1);
    check("t5_datavalid", 32'(datavalid_a), 32'd0);
    check("t5_counter", 32'(counter_a), 32'd63);
    check("t5_in_ctrl", 32'(in_ctrl_a), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_frame_done", 32'(frame_done_a), 32'd0);
    qa.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("t5_no_fd", 32'(fd_a - fd0), 32'd0);
    check("t5_still_idle", 32'(hold_a), 32'd1);

    // Small instance: 3 prepare cycles, 16 beats
    push_b();
    dataind_b = 1'b1;
    step();
    dataind_b = 1'b0;
    check("t6_p1_in_ctrl", 32'(in_ctrl_b), 32'd1);
    check("t6_p1_hold", 32'(hold_b), 32'd0);
    check("t6_p1_valid", 32'(datavalid_b), 32'd0);
    step();
    check("t6_p2_valid", 32'(datavalid_b), 32'd0);
    step();
    check("t6_p3_valid", 32'(datavalid_b), 32'd0);
    check("t6_p3_in_ctrl", 32'(in_ctrl_b), 32'd1);
    step();
    check("t6_first_valid", 32'(datavalid_b), 32'd1);
    check("t6_first_counter", 32'(counter_b), 32'd0);
    done = 0;
    for (int i = 0; i < 200 && done == 0; i++) begin
      step();
      if (frame_done_b) done = 1;
    end
    check("t6_frame", 32'(done), 32'd1);
    step();
    check("t6_fd_count", 32'(fd_b), 32'd1);
    check("t6_q_empty", 32'(qb.size()), 32'd0);
    check("t6_idle_hold", 32'(hold_b), 32'd1);
    check("t6_no_overrun", 32'(ov_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_output_sequencer.md
Name: fft_output_sequencer

Overview:
- Parametrised output-side sequencer for the FFT processor. Generalises the fixed 64-point output counter to 2^POINTS_LOG2 points, with configurable prepare latency and control-window length.
- Adds downstream backpressure (out_ready), back-to-back frame chaining, a frame_done pulse and overrun flagging.
- Drives the output-stage muxes (in_ctrl_all_out), the pipeline hold (hold_all_out) and the output index.

Parameters:
- POINTS_LOG2, 6, log2 of points per frame; N = 2^POINTS_LOG2; legal range 2..12.
- PREP_CYCLES, 1, cycles spent in PREPARE before the first valid beat; must be ≥1.
- CTRL_BEATS, 7, number of beats (counter 0..CTRL_BEATS-1) during which in_ctrl_all_out stays high; legal range 0..N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dataind  in  1  frame-ready indication from the core; single-cycle or level.
- out_ready  in  1  downstream accepts the current beat.
- counter_o  out  POINTS_LOG2  natural-order beat counter.
- index_o  out  POINTS_LOG2  output bin index (see Optional Feature).
- datavalid  out  1  beat valid.
- in_ctrl_all_out  out  1  output-stage mux control.
- hold_all_out  out  1  pipeline hold; high when idle.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  high in PREPARE or COUNTING.
- overrun  out  1  one-cycle pulse when a start request is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=all ones, prep_cnt=0, pending=0.
  - datavalid=0, in_ctrl_all_out=0, hold_all_out=1, frame_done=0, busy=0, overrun=0.
  - Applies immediately, including mid-frame. The frame is abandoned with no frame_done.
- All outputs are registered except index_o, which is combinational from counter.
- accept = datavalid & out_ready.
- IDLE:
  - Outputs: hold=1, in_ctrl=0, datavalid=0, busy=0; counter held.
  - dataind=1 -> PREPARE next cycle, with prep_cnt=0, in_ctrl=1, hold=0, busy=1.
- PREPARE:
  - Outputs: in_ctrl=1, hold=0, datavalid=0; prep_cnt increments each cycle.
  - When prep_cnt==PREP_CYCLES-1: counter<=0, datavalid<=1, state<=COUNTING.
  - dataind in this state sets pending.
- COUNTING:
  - No accept (stall): counter, datavalid, in_ctrl and state all hold.
  - Accept with counter<N-1:
    - counter<=counter+1.
    - in_ctrl<=(counter+1<CTRL_BEATS).
  - Accept with counter==N-1 (last beat):
    - frame_done<=1 for one cycle; counter<=all ones (wraps to 0 at the next prepare).
    - If pending or dataind: go to PREPARE (prep_cnt=0, in_ctrl=1, hold stays 0, busy stays 1), and clear pending.
    - Otherwise: go to IDLE (datavalid=0, in_ctrl=0, hold=1, busy=0).
  - in_ctrl on the first beat is high only if CTRL_BEATS>0. With CTRL_BEATS=0, in_ctrl drops as COUNTING is entered.
- Pending and overrun:
  - dataind while busy and not on a last-beat accept: sets pending.
  - If pending is already 1, the request is dropped and overrun pulses for one cycle.
  - dataind coincident with the last-beat accept starts the next frame directly and does not raise overrun.
- Throughput: with out_ready held high, a frame occupies PREP_CYCLES+N cycles, and back-to-back frames repeat with no idle gap.
- Counter arithmetic is POINTS_LOG2 bits, modulo N. No other wrap is possible because COUNTING exits at N-1.

Optional Feature:
- Macro: OUTSEQ_BITREV_EN.
- Defined: index_o = bit-reversed counter, e.g. POINTS_LOG2=6, counter=1 -> index_o=32, counter=6 -> index_o=24.
- Undefined: index_o = counter_o.
- No other behaviour changes, and timing is identical.

Test Plan:
- Reset, then dataind pulse with defaults and out_ready=1:
  - Cycle 1: in_ctrl=1, hold=0.
  - Cycle 2: datavalid=1, counter=0.
  - in_ctrl falls after counter=6 (first low at counter=7).
  - Exactly 64 beats with counter 0..63; frame_done pulses once; back in IDLE with hold=1.
- Backpressure: drop out_ready at counter=10 for 5 cycles -> counter stays 10 and datavalid stays 1 throughout; resumes at 11; total beats still 64.
- Back-to-back: dataind asserted at counter=40 -> pending set; after counter=63, PREPARE follows immediately with hold never rising; the second frame delivers 64 beats; overrun never pulses.
- Overrun: dataind at counter=5 and again at counter=20 -> overrun pulses once at the second request; only one follow-on frame runs.
- Async reset asserted at counter=30 -> all outputs take reset values immediately (hold=1, datavalid=0, counter=63), with no frame_done.
- POINTS_LOG2=4, PREP_CYCLES=3, CTRL_BEATS=2, OUTSEQ_BITREV_EN defined:
  - 3 prepare cycles, then 16 beats.
  - in_ctrl high through counter=1.
  - index_o sequence 0,8,4,12,2,...,15.
